// File: rtl/packet_bit_serializer.sv
// packet_bit_serializer
// Captures a parallel byte packet on a one-cycle send pulse and shifts it out
// as a framed serial stream: alternating preamble, sync byte, then payload.
// Bytes go out from index 0 upward and each byte goes out MSB first. Every bit
// is held for CLKS_PER_BIT clocks, with a strobe in the first clock of each bit.
// Optional build macro: PACKET_CRC8_EN appends a CRC-8 (poly 0x07, init 0x00)
// over the payload after the last payload bit.
module packet_bit_serializer #(
  parameter int unsigned PACKET_WIDTH  = 8,
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = 8'hD3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PACKET_WIDTH-1:0][7:0] sys_packet,
  input  logic                         send,
  output logic                         bit_out,
  output logic                         bit_strobe,
  output logic                         tx_active,
  output logic                         done,
  output logic                         overrun
);

  localparam int unsigned PAYLOAD_BITS = 8 * PACKET_WIDTH;
  localparam int unsigned MAX_BITS_A   = (PREAMBLE_BITS > PAYLOAD_BITS) ? PREAMBLE_BITS : PAYLOAD_BITS;
  localparam int unsigned MAX_BITS     = (MAX_BITS_A > 8) ? MAX_BITS_A : 8;
  // One guard bit on top of what each counter has to reach.
  localparam int unsigned CLK_CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_CNT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [CLK_CNT_W-1:0] CLK_LAST  = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_CNT_W-1:0] CLK_ONE   = CLK_CNT_W'(1);
  localparam logic [CLK_CNT_W-1:0] CLK_ZERO  = CLK_CNT_W'(0);
  localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BYTE_LAST = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] PAY_LAST  = BIT_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_ZERO  = BIT_CNT_W'(0);

`ifdef PACKET_CRC8_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    PAYLOAD  = 3'd3,
    CRC      = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2,
    PAYLOAD  = 2'd3
  } state_t;
`endif

  state_t                  state_r;
  logic [CLK_CNT_W-1:0]    clk_cnt_r;
  logic [BIT_CNT_W-1:0]    bit_cnt_r;
  // Remaining payload bits; the next bit to transmit sits in the MSB.
  logic [PAYLOAD_BITS-1:0] shift_r;
`ifdef PACKET_CRC8_EN
  logic [7:0]              crc_r;
`endif

  logic bit_end_s;

  // Reorders the packet so byte 0 lands in the top byte of the shift register.
  function automatic logic [PAYLOAD_BITS-1:0] order_payload(
    input logic [PACKET_WIDTH-1:0][7:0] pkt
  );
    logic [PAYLOAD_BITS-1:0] flat;
    flat = '0;
    for (int i = 0; i < int'(PACKET_WIDTH); i++) begin
      flat[PAYLOAD_BITS - 8 - 8*i +: 8] = pkt[i];
    end
    return flat;
  endfunction

`ifdef PACKET_CRC8_EN
  // One serial step of CRC-8, polynomial x^8+x^2+x+1, MSB-first data.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  // Last clock of the current bit period.
  always_comb begin
    bit_end_s = (clk_cnt_r == CLK_LAST);
  end

  // Frame sequencer: bit timing, state transitions, serial data and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      clk_cnt_r  <= CLK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= '0;
`ifdef PACKET_CRC8_EN
      crc_r      <= 8'h00;
`endif
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      if (send && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          clk_cnt_r <= CLK_ZERO;
          bit_cnt_r <= BIT_ZERO;
          if (send) begin
            shift_r    <= order_payload(sys_packet);
`ifdef PACKET_CRC8_EN
            crc_r      <= 8'h00;
`endif
            state_r    <= PREAMBLE;
            bit_out    <= 1'b1;
            bit_strobe <= 1'b1;
            tx_active  <= 1'b1;
          end else begin
            bit_out   <= 1'b0;
            tx_active <= 1'b0;
          end
        end

        PREAMBLE: begin
          if (bit_end_s) begin
            clk_cnt_r  <= CLK_ZERO;
            bit_strobe <= 1'b1;
            if (bit_cnt_r == PRE_LAST) begin
              state_r   <= SYNC;
              bit_cnt_r <= BIT_ZERO;
              bit_out   <= SYNC_WORD[7];
            end else begin
              // Bit k of the preamble is 1 for even k; the next index is
              // bit_cnt_r+1, whose parity is the inverse of bit_cnt_r's.
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
              bit_out   <= bit_cnt_r[0];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_ONE;
          end
        end

        SYNC: begin
          if (bit_end_s) begin
            clk_cnt_r  <= CLK_ZERO;
            bit_strobe <= 1'b1;
            if (bit_cnt_r == BYTE_LAST) begin
              state_r   <= PAYLOAD;
              bit_cnt_r <= BIT_ZERO;
              bit_out   <= shift_r[PAYLOAD_BITS-1];
              shift_r   <= {shift_r[PAYLOAD_BITS-2:0], 1'b0};
`ifdef PACKET_CRC8_EN
              crc_r     <= crc8_step(crc_r, shift_r[PAYLOAD_BITS-1]);
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
              bit_out   <= SYNC_WORD[3'd6 - bit_cnt_r[2:0]];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_ONE;
          end
        end

        PAYLOAD: begin
          if (bit_end_s) begin
            clk_cnt_r <= CLK_ZERO;
            if (bit_cnt_r == PAY_LAST) begin
              bit_cnt_r <= BIT_ZERO;
`ifdef PACKET_CRC8_EN
              // CRC already covers every payload bit emitted.
              state_r    <= CRC;
              bit_strobe <= 1'b1;
              bit_out    <= crc_r[7];
              crc_r      <= {crc_r[6:0], 1'b0};
`else
              state_r   <= IDLE;
              bit_out   <= 1'b0;
              tx_active <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              bit_cnt_r  <= bit_cnt_r + BIT_ONE;
              bit_strobe <= 1'b1;
              bit_out    <= shift_r[PAYLOAD_BITS-1];
              shift_r    <= {shift_r[PAYLOAD_BITS-2:0], 1'b0};
`ifdef PACKET_CRC8_EN
              crc_r      <= crc8_step(crc_r, shift_r[PAYLOAD_BITS-1]);
`endif
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_ONE;
          end
        end

`ifdef PACKET_CRC8_EN
        CRC: begin
          if (bit_end_s) begin
            clk_cnt_r <= CLK_ZERO;
            if (bit_cnt_r == BYTE_LAST) begin
              state_r   <= IDLE;
              bit_cnt_r <= BIT_ZERO;
              bit_out   <= 1'b0;
              tx_active <= 1'b0;
              done      <= 1'b1;
            end else begin
              bit_cnt_r  <= bit_cnt_r + BIT_ONE;
              bit_strobe <= 1'b1;
              bit_out    <= crc_r[7];
              crc_r      <= {crc_r[6:0], 1'b0};
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_ONE;
          end
        end
`endif

        default: begin
          state_r   <= IDLE;
          clk_cnt_r <= CLK_ZERO;
          bit_cnt_r <= BIT_ZERO;
          bit_out   <= 1'b0;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_bit_serializer.sv
// Scoreboard bench for packet_bit_serializer. The stimulus process predicts
// each accepted frame (bit values, strobe cycles, done cycle, active window,
// overrun onset) from the framing rules; a negedge monitor compares the DUT
// against those predictions every cycle.
module tb_packet_bit_serializer;

  localparam int PW  = 2;
  localparam int CPB = 4;
  localparam int PB  = 16;
  localparam logic [7:0] SYNC = 8'hD3;
`ifdef PACKET_CRC8_EN
  localparam int NBITS = PB + 8 + 8*PW + 8;
`else
  localparam int NBITS = PB + 8 + 8*PW;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic send = 1'b0;
  logic [PW-1:0][7:0] sys_packet = '0;
  logic bit_out, bit_strobe, tx_active, done, overrun;

  packet_bit_serializer #(
    .PACKET_WIDTH (PW),
    .CLKS_PER_BIT (CPB),
    .PREAMBLE_BITS(PB),
    .SYNC_WORD    (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sys_packet(sys_packet),
    .send      (send),
    .bit_out   (bit_out),
    .bit_strobe(bit_strobe),
    .tx_active (tx_active),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge it holds the index of the current cycle.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int exp_cyc_q[$];
  bit exp_bit_q[$];
  int exp_done_q[$];
  int act_start = 0;
  int act_end   = -1;
  int ovr_cycle = 32'h7fffffff;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [PW-1:0][7:0] rand_pkt();
    logic [PW-1:0][7:0] p;
    for (int i = 0; i < PW; i++) p[i] = 8'($urandom);
    return p;
  endfunction

  // Reference frame: preamble 1010.., sync MSB first, bytes 0.. MSB first,
  // then (optionally) the CRC-8 of the payload bytes.
  task automatic push_frame(input logic [PW-1:0][7:0] pkt, input int s);
    bit bits[$];
    logic [7:0] sw;
    logic [7:0] by;
    logic [7:0] crc;
    sw = SYNC;
    for (int i = 0; i < PB; i++) bits.push_back((i % 2) == 0);
    for (int j = 7; j >= 0; j--) bits.push_back(sw[j]);
    crc = 8'h00;
    for (int b = 0; b < PW; b++) begin
      by = pkt[b];
      for (int j = 7; j >= 0; j--) bits.push_back(by[j]);
      crc = crc ^ by;
      for (int k = 0; k < 8; k++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
    end
`ifdef PACKET_CRC8_EN
    for (int j = 7; j >= 0; j--) bits.push_back(crc[j]);
`endif
    for (int k = 0; k < bits.size(); k++) begin
      exp_cyc_q.push_back(s + 1 + k*CPB);
      exp_bit_q.push_back(bits[k]);
    end
    exp_done_q.push_back(s + FRAME_CLKS + 1);
    act_start = s + 1;
    act_end   = s + FRAME_CLKS;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a send sampled at the coming edge and record the expected outcome.
  task automatic do_send(input logic [PW-1:0][7:0] pkt);
    int e;
    e = edge_cnt;
    send = 1'b1;
    sys_packet = pkt;
    if (e > act_end) push_frame(pkt, e);
    else if (ovr_cycle > e + 1) ovr_cycle = e + 1;
    wait_cycles(1);
    send = 1'b0;
    sys_packet = rand_pkt();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    exp_cyc_q.delete();
    exp_bit_q.delete();
    exp_done_q.delete();
    act_start = 0;
    act_end   = -1;
    ovr_cycle = 32'h7fffffff;
  endtask

  // Monitor: compares every observable output each cycle.
  always @(negedge clk) begin
    int cyc;
    bit exp_act;
    bit exp_done;
    if (mon_en) begin
      cyc = edge_cnt;
      exp_act = (cyc >= act_start) && (cyc <= act_end);
      chk("tx_active", tx_active, exp_act);
      if (!exp_act) chk("idle_bit_out", bit_out, 1'b0);
      chk("overrun", overrun, cyc >= ovr_cycle);
      if (bit_strobe) begin
        if (exp_cyc_q.size() == 0) begin
          chk("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          chk("strobe_cycle", cyc, exp_cyc_q.pop_front());
          chk("bit", bit_out, exp_bit_q.pop_front());
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        chk("missing_strobe", 1'b0, 1'b1);
        void'(exp_cyc_q.pop_front());
        void'(exp_bit_q.pop_front());
      end
      exp_done = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
      chk("done", done, exp_done);
      if (exp_done) void'(exp_done_q.pop_front());
    end
  end

  initial begin
    logic [PW-1:0][7:0] pkt;

    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    mon_en = 1'b1;

    // Idle stability.
    wait_cycles(200);

    // Basic frame, then a back-to-back send in the done cycle.
    pkt[0] = 8'hA5;
    pkt[1] = 8'h0F;
    do_send(pkt);
    wait_cycles(FRAME_CLKS);
    pkt[0] = 8'h00;
    pkt[1] = 8'h80;
    do_send(pkt);

    // Reset 70 cycles into the second frame, new send 10 cycles later.
    wait_cycles(69);
    do_reset();
    wait_cycles(9);
    do_send(rand_pkt());

    // Overrun: a second send 50 cycles into the frame is ignored.
    wait_cycles(49);
    pkt[0] = 8'hFF;
    pkt[1] = 8'hFF;
    do_send(pkt);
    wait_cycles(FRAME_CLKS);

    // Random sends: gaps span in-frame (overrun), done-cycle and idle cases.
    for (int n = 0; n < 30; n++) begin
      wait_cycles($urandom_range(0, FRAME_CLKS + 12));
      if ($urandom_range(0, 9) == 0) do_reset();
      do_send(rand_pkt());
    end

    wait_cycles(FRAME_CLKS + 10);
    mon_en = 1'b0;
    chk("bits_left", exp_cyc_q.size(), 0);
    chk("dones_left", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
